// File: rtl/datapath_mem_seq_if.sv
// rtl/datapath_mem_seq_if.sv - op port bundle between control unit and datapath
interface datapath_mem_seq_if #(
  parameter int DATA_W = 64,
  parameter int RA_W   = 5
);
  logic              op_valid;
  logic              op_ready;
  logic              write;
  logic [RA_W-1:0]   rdAddrA;
  logic [RA_W-1:0]   rdAddrB;
  logic [RA_W-1:0]   wrAddr;
  logic [DATA_W-1:0] K;
  logic              B_sel;
  logic [4:0]        FS;
  logic              C_in;
  logic              EN_ALU;
  logic              EN_RAM;
  logic              ramWrite;
  logic              ramOut;
  logic              set_flags;

  modport master (
    output op_valid, write, rdAddrA, rdAddrB, wrAddr, K, B_sel, FS, C_in,
           EN_ALU, EN_RAM, ramWrite, ramOut, set_flags,
    input  op_ready
  );

  modport slave (
    input  op_valid, write, rdAddrA, rdAddrB, wrAddr, K, B_sel, FS, C_in,
           EN_ALU, EN_RAM, ramWrite, ramOut, set_flags,
    output op_ready
  );
endinterface

// File: rtl/datapath_mem_seq.sv
// rtl/datapath_mem_seq.sv - register file, ALU and multi-cycle data RAM behind a valid/ready op port
module datapath_mem_seq #(
  parameter int  DATA_W    = 64,
  parameter int  REG_CNT   = 32,
  parameter int  RAM_DEPTH = 256,
  parameter int  RAM_LAT   = 2,
  localparam int RA_W      = $clog2(REG_CNT),
  localparam int MA_W      = $clog2(RAM_DEPTH),
  localparam int SH_W      = $clog2(DATA_W),
  localparam int CNT_W     = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  datapath_mem_seq_if.slave    op,
  output logic [3:0]           flags,
  output logic [DATA_W-1:0]    bus_out,
  output logic                 mem_done,
  input  logic [RA_W-1:0]      dbg_addr,
  output logic [DATA_W-1:0]    dbg_data
);
  localparam logic [RA_W-1:0] ZERO_REG = RA_W'(REG_CNT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [DATA_W-1:0] regs_q [REG_CNT];
  logic [DATA_W-1:0] ram_q  [RAM_DEPTH];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_ready_q, op_ready_d;
  logic              mem_done_q, mem_done_d;
  logic [3:0]        flags_q, flags_d;
  logic [DATA_W-1:0] bus_out_q, bus_out_d;
  logic [MA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [RA_W-1:0]   wr_addr_q, wr_addr_d;
  logic              write_q, write_d;
  logic              st_q, st_d;
  logic              ld_q, ld_d;

  logic [DATA_W-1:0] rd_a, rd_b, opa, opb, alu_res, ram_rd;
  logic [DATA_W:0]   sum;
  logic              alu_c, alu_v;
  logic [3:0]        alu_flags;
  logic              accept;
  logic              reg_we, ram_we;
  logic [RA_W-1:0]   reg_waddr;
  logic [DATA_W-1:0] reg_wdata;

  assign rd_a     = (op.rdAddrA == ZERO_REG) ? '0 : regs_q[op.rdAddrA];
  assign rd_b     = (op.rdAddrB == ZERO_REG) ? '0 : regs_q[op.rdAddrB];
  assign dbg_data = (dbg_addr == ZERO_REG) ? '0 : regs_q[dbg_addr];
  assign ram_rd   = ram_q[addr_q];
  assign accept   = op.op_valid && op_ready_q;

  assign op.op_ready = op_ready_q;
  assign flags       = flags_q;
  assign bus_out     = bus_out_q;
  assign mem_done    = mem_done_q;

  always_comb begin
    opa   = op.FS[1] ? ~rd_a : rd_a;
    opb   = op.B_sel ? op.K : rd_b;
    opb   = op.FS[0] ? ~opb : opb;
    sum   = {1'b0, opa} + {1'b0, opb} + {{DATA_W{1'b0}}, op.C_in};
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op.FS[4:2])
      3'b000:  alu_res = opa & opb;
      3'b001:  alu_res = opa | opb;
      3'b010: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        // Overflow: operands agree in sign but the sum does not.
        alu_v   = (opa[DATA_W-1] == opb[DATA_W-1]) && (sum[DATA_W-1] != opa[DATA_W-1]);
      end
      3'b011:  alu_res = opa ^ opb;
      3'b100:  alu_res = opa << opb[SH_W-1:0];
      3'b101:  alu_res = opa >> opb[SH_W-1:0];
      default: alu_res = '0;
    endcase
    alu_flags = {alu_res[DATA_W-1], alu_res == '0, alu_c, alu_v};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_ready_d = op_ready_q;
    mem_done_d = 1'b0;
    flags_d    = flags_q;
    bus_out_d  = bus_out_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_addr_d  = wr_addr_q;
    write_d    = write_q;
    st_d       = st_q;
    ld_d       = ld_q;
    reg_we     = 1'b0;
    reg_waddr  = op.wrAddr;
    reg_wdata  = alu_res;
    ram_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op.set_flags) flags_d = alu_flags;
          if (op.EN_RAM) begin
            state_d    = BUSY;
            op_ready_d = 1'b0;
            cnt_d      = CNT_W'(RAM_LAT - 1);
            addr_d     = alu_res[MA_W-1:0];
            data_d     = rd_b;
            wr_addr_d  = op.wrAddr;
            write_d    = op.write;
            st_d       = op.ramWrite;
            ld_d       = !op.ramWrite && op.ramOut;
          end else if (op.write && op.EN_ALU) begin
            reg_we    = 1'b1;
            bus_out_d = alu_res;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d    = IDLE;
          op_ready_d = 1'b1;
          mem_done_d = 1'b1;
          if (st_q) begin
            ram_we    = 1'b1;
            bus_out_d = data_q;
          end else if (ld_q && write_q) begin
            reg_we    = 1'b1;
            reg_waddr = wr_addr_q;
            reg_wdata = ram_rd;
            bus_out_d = ram_rd;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    reg_we = reg_we && (reg_waddr != ZERO_REG);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_ready_q <= 1'b1;
      mem_done_q <= 1'b0;
      flags_q    <= '0;
      bus_out_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_addr_q  <= '0;
      write_q    <= 1'b0;
      st_q       <= 1'b0;
      ld_q       <= 1'b0;
      for (int i = 0; i < REG_CNT; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_ready_q <= op_ready_d;
      mem_done_q <= mem_done_d;
      flags_q    <= flags_d;
      bus_out_q  <= bus_out_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_addr_q  <= wr_addr_d;
      write_q    <= write_d;
      st_q       <= st_d;
      ld_q       <= ld_d;
      if (reg_we) regs_q[reg_waddr] <= reg_wdata;
    end
  end

  // RAM keeps its contents through reset; reset only blocks a pending store.
  always_ff @(posedge clk) begin
    if (reset && ram_we) ram_q[addr_q] <= data_q;
  end
endmodule

// File: tb/tb_datapath_mem_seq.sv
// tb/tb_datapath_mem_seq.sv - randomized self-checking bench for datapath_mem_seq
module tb_datapath_mem_seq;
  localparam int DATA_W = 64, REG_CNT = 32, RAM_DEPTH = 256, RAM_LAT = 2, RA_W = 5;

  typedef struct {
    logic [4:0]  a, b, w, fs;
    logic [63:0] k;
    logic write, bsel, cin, en_alu, en_ram, ram_wr, ram_out, set_flags;
  } op_t;

  logic clk = 1'b0, reset = 1'b0;
  logic [3:0]  flags;
  logic [63:0] bus_out, dbg_data;
  logic        mem_done;
  logic [4:0]  dbg_addr = '0;

  datapath_mem_seq_if #(.DATA_W(DATA_W), .RA_W(RA_W)) op_if ();

  datapath_mem_seq #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .RAM_DEPTH(RAM_DEPTH), .RAM_LAT(RAM_LAT)) dut (
    .clk(clk), .reset(reset), .op(op_if.slave), .flags(flags), .bus_out(bus_out),
    .mem_done(mem_done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #50 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  logic [63:0] reg_m [32];
  logic [63:0] ram_m [256];
  bit          ram_known [256];
  logic [7:0]  known_q [$];
  logic [3:0]  flags_m;
  logic [63:0] bus_m;
  op_t         pend;
  logic [7:0]  pend_addr;
  logic [63:0] pend_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rd_m(input logic [4:0] i);
    return (i == 5'd31) ? 64'd0 : reg_m[i];
  endfunction

  task automatic alu_m(input logic [4:0] fs, input logic [63:0] a_in, b_in, input logic cin,
                       output logic [63:0] res, output logic [3:0] f);
    logic [63:0] a, b;
    logic [64:0] u;
    logic signed [65:0] s;
    logic c, v;
    a = fs[1] ? ~a_in : a_in;
    b = fs[0] ? ~b_in : b_in;
    c = 0; v = 0;
    case (fs[4:2])
      0: res = a & b;
      1: res = a | b;
      2: begin
        u = 65'(a) + 65'(b) + 65'(cin);
        res = u[63:0];
        c = u[64];
        s = 66'($signed(a)) + 66'($signed(b)) + 66'(cin);
        v = (s > 66'sh7FFF_FFFF_FFFF_FFFF) || (s < -66'sh8000_0000_0000_0000);
      end
      3: res = a ^ b;
      4: res = a << (b % 64);
      5: res = a >> (b % 64);
      default: res = 0;
    endcase
    f = {res[63], res == 0, c, v};
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) reg_m[i] = 0;
    flags_m = 0;
    bus_m = 0;
  endtask

  task automatic model_accept(input op_t o);
    logic [63:0] res;
    logic [3:0]  f;
    alu_m(o.fs, rd_m(o.a), o.bsel ? o.k : rd_m(o.b), o.cin, res, f);
    if (o.set_flags) flags_m = f;
    if (o.en_ram) begin
      pend = o;
      pend_addr = res[7:0];
      pend_data = rd_m(o.b);
    end else if (o.write && o.en_alu) begin
      if (o.w != 31) reg_m[o.w] = res;
      bus_m = res;
    end
  endtask

  task automatic model_commit();
    if (pend.ram_wr) begin
      ram_m[pend_addr] = pend_data;
      if (!ram_known[pend_addr]) known_q.push_back(pend_addr);
      ram_known[pend_addr] = 1;
      bus_m = pend_data;
    end else if (pend.ram_out && pend.write) begin
      if (pend.w != 31) reg_m[pend.w] = ram_m[pend_addr];
      bus_m = ram_m[pend_addr];
    end
  endtask

  task automatic drive(input op_t o);
    op_if.rdAddrA = o.a; op_if.rdAddrB = o.b; op_if.wrAddr = o.w; op_if.FS = o.fs;
    op_if.K = o.k; op_if.write = o.write; op_if.B_sel = o.bsel; op_if.C_in = o.cin;
    op_if.EN_ALU = o.en_alu; op_if.EN_RAM = o.en_ram; op_if.ramWrite = o.ram_wr;
    op_if.ramOut = o.ram_out; op_if.set_flags = o.set_flags;
  endtask

  task automatic peek(input logic [4:0] i, output logic [63:0] v);
    dbg_addr = i;
    #1;
    v = dbg_data;
  endtask

  task automatic check_state(input string tag);
    logic [63:0] v;
    for (int i = 0; i < 32; i++) begin
      peek(5'(i), v);
      check_eq($sformatf("%s x%0d", tag, i), v, rd_m(5'(i)));
    end
    check_eq({tag, " bus_out"}, bus_out, bus_m);
    check_eq({tag, " flags"}, 64'(flags), 64'(flags_m));
  endtask

  // Called one unit after a rising edge; returns once the op is checked.
  task automatic run_op(input string tag, input op_t o);
    drive(o);
    op_if.op_valid = 1;
    #1;
    check_eq({tag, " ready_idle"}, op_if.op_ready, 1);
    model_accept(o);
    @(posedge clk); #1;
    op_if.op_valid = 0;
    if (o.en_ram) begin
      for (int c = 0; c < RAM_LAT; c++) begin
        check_eq($sformatf("%s ready_busy%0d", tag, c), op_if.op_ready, 0);
        check_eq($sformatf("%s done_early%0d", tag, c), mem_done, 0);
        @(posedge clk); #1;
      end
      model_commit();
      check_eq({tag, " ready_after"}, op_if.op_ready, 1);
      check_eq({tag, " mem_done"}, mem_done, 1);
    end else begin
      check_eq({tag, " mem_done_alu"}, mem_done, 0);
    end
    check_state(tag);
  endtask

  function automatic op_t base();
    op_t o;
    o.a = 0; o.b = 0; o.w = 0; o.fs = 5'b01000; o.k = 0;
    o.write = 0; o.bsel = 0; o.cin = 0; o.en_alu = 0; o.en_ram = 0;
    o.ram_wr = 0; o.ram_out = 0; o.set_flags = 0;
    return o;
  endfunction

  function automatic op_t alu(input logic [4:0] fs, a, b, w, input logic bsel,
                              input logic [63:0] k, input logic cin, input logic sf);
    op_t o = base();
    o.fs = fs; o.a = a; o.b = b; o.w = w; o.bsel = bsel; o.k = k; o.cin = cin;
    o.set_flags = sf; o.write = 1; o.en_alu = 1;
    return o;
  endfunction

  function automatic op_t mem(input logic st, input logic [63:0] addr, input logic [4:0] b, w);
    op_t o = base();
    o.a = 31; o.bsel = 1; o.k = addr; o.b = b; o.w = w; o.en_ram = 1;
    o.ram_wr = st; o.ram_out = !st; o.write = 1;
    return o;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    logic [63:0] v;
    drive(base());
    op_if.op_valid = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1;
    check_eq("reset op_ready", op_if.op_ready, 1);
    check_eq("reset mem_done", mem_done, 0);
    check_state("reset");

    run_op("t1 add x1", alu(5'b01000, 31, 0, 1, 1, 4, 0, 0));
    run_op("t1 add x2", alu(5'b01000, 31, 0, 2, 1, 2, 0, 0));
    peek(1, v); check_eq("t1 x1", v, 4);
    peek(2, v); check_eq("t1 x2", v, 2);

    o = mem(1, 0, 2, 0); o.a = 1;
    run_op("t2 store", o);
    o = mem(0, 0, 0, 3); o.a = 1;
    run_op("t2 load", o);
    peek(3, v); check_eq("t2 x3", v, 2);
    check_eq("t2 bus_out", bus_out, 2);

    run_op("t3 sub", alu(5'b01001, 1, 2, 4, 0, 0, 1, 1));
    check_eq("t3 sub flags", 64'(flags), 64'(4'b0010));
    run_op("t3 subneg", alu(5'b01001, 2, 1, 4, 0, 0, 1, 1));
    peek(4, v); check_eq("t3 x4", v, 64'hFFFF_FFFF_FFFF_FFFE);
    check_eq("t3 subneg flags", 64'(flags), 64'(4'b1000));
    run_op("t3 maxpos", alu(5'b01000, 31, 0, 5, 1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0));
    run_op("t3 ovf", alu(5'b01000, 5, 0, 6, 1, 1, 0, 1));
    check_eq("t3 ovf flags", 64'(flags), 64'(4'b1001));

    run_op("t4 x31", alu(5'b01000, 31, 0, 31, 1, 5, 0, 0));
    peek(31, v); check_eq("t4 x31", v, 0);
    run_op("t4 store wrap", mem(1, 64'h104, 5, 0));
    run_op("t4 load", mem(0, 4, 0, 7));
    peek(7, v); check_eq("t4 x7", v, 64'h7FFF_FFFF_FFFF_FFFF);

    // Store of x1 to RAM[4], aborted by reset one cycle after acceptance.
    drive(mem(1, 4, 1, 0));
    op_if.op_valid = 1;
    @(posedge clk); #1;
    op_if.op_valid = 0;
    reset = 0;
    @(posedge clk); #1;
    reset = 1;
    model_reset();
    check_eq("t5 ready", op_if.op_ready, 1);
    check_eq("t5 mem_done", mem_done, 0);
    check_state("t5 regs");
    @(posedge clk); #1;
    check_eq("t5 mem_done late", mem_done, 0);
    run_op("t5 load", mem(0, 4, 0, 7));
    peek(7, v); check_eq("t5 ram4 kept", v, 64'h7FFF_FFFF_FFFF_FFFF);

    run_op("t6 seed", alu(5'b01000, 31, 0, 5, 1, 10, 0, 0));
    o = mem(1, 9, 5, 0);
    drive(o);
    op_if.op_valid = 1;
    model_accept(o);
    @(posedge clk); #1;
    o = alu(5'b01000, 5, 0, 5, 1, 3, 0, 0);
    drive(o);
    check_eq("t6 ready T", op_if.op_ready, 0);
    @(posedge clk); #1;
    check_eq("t6 ready T1", op_if.op_ready, 0);
    @(posedge clk); #1;
    model_commit();
    check_eq("t6 ready T2", op_if.op_ready, 1);
    check_eq("t6 mem_done", mem_done, 1);
    check_state("t6 pre");
    model_accept(o);
    @(posedge clk); #1;
    op_if.op_valid = 0;
    check_state("t6 post");
    peek(5, v); check_eq("t6 x5 once", v, 13);

    for (int n = 0; n < 200; n++) begin
      int kind;
      o = base();
      o.a = 5'($urandom); o.b = 5'($urandom); o.w = 5'($urandom); o.fs = 5'($urandom);
      o.k = ($urandom % 3 == 0) ? 64'($urandom_range(0, 300)) : {$urandom, $urandom};
      o.bsel = 1'($urandom); o.cin = 1'($urandom); o.set_flags = 1'($urandom);
      o.write = ($urandom % 5) != 0; o.en_alu = ($urandom % 6) != 0;
      kind = $urandom_range(0, 3);
      if (kind == 3 && known_q.size() == 0) kind = 2;
      if (kind == 2) begin
        o.en_ram = 1; o.ram_wr = 1; o.ram_out = 1'($urandom);
      end else if (kind == 3) begin
        o.en_ram = 1; o.a = 31; o.bsel = 1; o.fs = 5'b01000; o.cin = 0;
        o.k = 64'(known_q[$urandom_range(0, known_q.size() - 1)]) + 64'(256 * $urandom_range(0, 3));
        o.ram_out = ($urandom % 5) != 0;
      end
      run_op($sformatf("rnd%0d", n), o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/datapath_mem_seq.md
# datapath_mem_seq

Parametrised successor to the fixed-width DataPath. It combines a register file with a hardwired zero register, an ALU, and a data RAM, behind a single-issue valid/ready op port. RAM accesses take a configurable multi-cycle latency, sequenced by an internal state machine. It sits between the control unit and memory in the processor, and exposes one debug read port instead of per-register output wires.

## Interface
- DATA_W, 64, datapath and register width
- REG_CNT, 32, register count, power of 2; index REG_CNT-1 reads 0 and ignores writes
- RAM_DEPTH, 256, RAM words of DATA_W, power of 2
- RAM_LAT, 2, cycles per RAM access, ≥1
- (derived) RA_W = log2(REG_CNT), MA_W = log2(RAM_DEPTH)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-low
- op_valid  input  1  op present
- op_ready  output  1  block can accept an op
- write  input  1  register writeback enable
- rdAddrA, rdAddrB, wrAddr  input  RA_W  read A, read B, and write register indices
- K  input  DATA_W  constant operand
- B_sel  input  1  ALU B operand: 1 = K, 0 = reg B
- FS  input  5  ALU function select
- C_in  input  1  adder carry-in
- EN_ALU  input  1  ALU result is writeback source
- EN_RAM  input  1  op is a RAM access
- ramWrite  input  1  store (with EN_RAM)
- ramOut  input  1  load (with EN_RAM)
- set_flags  input  1  update flags from this op's ALU result
- flags  output  4  {N,Z,C,V}, registered
- bus_out  output  DATA_W  last writeback or store value, registered
- mem_done  output  1  one-cycle pulse on RAM access completion
- dbg_addr  input  RA_W  debug register index
- dbg_data  output  DATA_W  combinational read of register dbg_addr

## Operation
- **Accept:** an op is accepted on an edge with op_valid && op_ready. All op fields are ignored otherwise.
- **ALU operands:**
  - A = reg[rdAddrA]
  - B = B_sel ? K : reg[rdAddrB]
  - B is inverted when FS[0]=1; A is inverted when FS[1]=1.
- **ALU function, FS[4:2]:**
  - 000 AND, 001 OR, 010 ADD (A+B+C_in), 011 XOR
  - 100 A << B[log2(DATA_W)-1:0], 101 logical right shift by the same amount
  - 11x gives result 0
- **Flags:**
  - N = result MSB; Z = (result==0)
  - For ADD: C = carry out, V = signed overflow. For all other functions C = V = 0.
  - flags update only when set_flags is 1 on an accepted op.
- **Non-RAM op (EN_RAM=0):**
  - Completes at the accept edge.
  - If write && EN_ALU, the result goes to reg[wrAddr] and to bus_out.
  - If write && !EN_ALU, nothing is written.
- **RAM op (EN_RAM=1):**
  - On accept, capture: address = ALU result[MA_W-1:0] (wraps mod RAM_DEPTH), store data = reg[rdAddrB] (independent of B_sel), wrAddr, write, ramWrite, ramOut.
  - If ramWrite=1, the op is a store and ramOut is ignored. If ramWrite=0 and ramOut=1, the op is a load. If both are 0, the op is a no-op that still takes RAM_LAT cycles.
- **State machine:**
  - IDLE: op_ready=1. An accepted RAM op moves to BUSY and loads cnt = RAM_LAT-1.
  - BUSY: op_ready=0; cnt decrements each edge.
  - At the edge where cnt==0, the access commits and the state returns to IDLE:
    - store: RAM[addr] ← data, bus_out ← data
    - load with write=1: reg[wrAddr] ← RAM[addr], bus_out ← RAM[addr]
    - load with write=0: no register write
- **Register file:** reads are combinational with no write bypass; a read in the same cycle as a write returns the old value. The register write port is used only at an ALU accept or a load commit, which are mutually exclusive.
- **Reset (reset=0 at an edge):**
  - All registers ← 0, flags ← 0, bus_out ← 0, mem_done ← 0, state ← IDLE.
  - RAM contents are not cleared.
  - Reset during BUSY aborts the access: no RAM write, no register write, no mem_done.

## Timing
- ALU op accepted at edge T: the register, bus_out and flags are visible from T+1. Back-to-back ALU ops are possible every cycle.
- RAM op accepted at edge T:
  - op_ready=0 for cycles T..T+RAM_LAT-1.
  - The commit edge is T+RAM_LAT.
  - mem_done=1 and op_ready=1 in the cycle after the commit edge.
  - The next op can be accepted at edge T+RAM_LAT+1.
- RAM_LAT=1: commit occurs at edge T+1.
- Ops offered while op_ready=0 are held by the sender and are not lost or duplicated.
- After reset is released, op_ready=1 in the first cycle.

## Test plan
All scenarios use DATA_W=64, REG_CNT=32, RAM_DEPTH=256, RAM_LAT=2.

1. **Immediate add:** ADD K=4 to X1, then K=2 to X2 (FS=01000, B_sel=1, rdAddrA=31) -> dbg X1=4, X2=2; one op per cycle; op_ready stays 1.
2. **Store/load round trip:** store (rdAddrA=1, K=0, rdAddrB=2), then load to X3 with the same address -> RAM[4]=2, X3=2; op_ready low exactly 2 cycles per access; mem_done pulses twice; bus_out=2.
3. **Subtract and flags:** SUB (FS=01001, C_in=1), X1−X2 with set_flags -> 2, flags 0010. X2−X1 -> 0xFFFF_FFFF_FFFF_FFFE, N=1, C=0. Max positive + 1 -> V=1.
4. **Zero register and address wrap:** write to X31 -> reads 0. Store with address 0x104 -> lands at RAM[4].
5. **Reset mid-store:** reset asserted one cycle after store accept -> RAM[addr] unchanged, no mem_done, all regs 0, op_ready=1 next cycle.
6. **Hold while busy:** op_valid held during BUSY with a pending ALU op -> that op executes exactly once, at edge T+3.
